serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 165 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: byte-serial adder/subtractor. Each operation runs one
// 8-bit ripple-carry slice over the operand bytes, least significant byte first.
// The operation takes NBYTES cycles in ADD, followed by a one-cycle DONE state.
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the `sub` port.
// With sub=1 the block computes A - B as A + ~B + 1, and carry_in is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin an operation (sampled only in IDLE or DONE)
//   op_a/op_b  operands, 8*NBYTES bits, captured when start is accepted
//   carry_in   initial carry, captured when start is accepted
//   sub        subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy       high while bytes are being processed
//   done       one-cycle pulse; result, carry_out and overflow are valid
//   result     sum or difference, held until the next accepted start
//   carry_out  carry out of the most significant byte (no-borrow when subtracting)
//   overflow   signed overflow of the full-width operation
module serial_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  carry_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned W     = 8 * NBYTES;
  localparam int unsigned IDX_W = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             busy_d;
  logic             done_d;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic             sub_eff;
  logic [W-1:0]     b_eff;
  logic             cin_eff;
  logic             accept;
  logic             last_byte;

  logic [7:0]       a_byte;
  logic [7:0]       b_byte;
  logic [7:0]       sum_byte;
  logic [8:0]       c;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Operand actually added, and the carry that seeds the first byte.
  assign b_eff   = sub_eff ? ~op_b : op_b;
  assign cin_eff = sub_eff ? 1'b1 : carry_in;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  // Select the current byte of each captured operand.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_byte = a_q[8*k +: 8];
        b_byte = b_q[8*k +: 8];
      end
    end
  end

  // Single 8-bit ripple-carry slice built from full-adder cells.
  assign c[0] = carry_q;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum_byte[i] = a_byte[i] ^ b_byte[i] ^ c[i];
    assign c[i+1]      = (a_byte[i] & b_byte[i]) | (c[i] & (a_byte[i] ^ b_byte[i]));
  end

  // State register, plus the registered copies of the status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (last_byte) state_d = S_DONE;
      S_DONE:  state_d = start ? S_ADD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so busy and done line up with the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_ADD:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, then process one byte per ADD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      idx_q   <= '0;
    end else if (state_q == S_ADD) begin
      for (int k = 0; k < int'(NBYTES); k++) begin
        if (idx_q == IDX_W'(k)) result[8*k +: 8] <= sum_byte;
      end
      carry_q <= c[8];
      if (last_byte) begin
        carry_out <= c[8];
        overflow  <= (a_byte[7] == b_byte[7]) && (sum_byte[7] != a_byte[7]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference model of one operation.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sb);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   s;
    bp     = sb ? ~b : b;
    s      = {1'b0, a} + {1'b0, bp} + (W+1)'(sb ? 1'b1 : cin);
    e.res  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, 64'(result), 64'(e.res));
      chk({tag, "_cout"},   64'(carry_out), 64'(e.cout));
      chk({tag, "_ovf"},    64'(overflow), 64'(e.ovf));
    end
  endtask

  // Called at a negedge; drives one operation and checks it to completion.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sb);
    int   lat;
    logic got;
    exp_t e;
    e = model(a, b, cin, sb);
    sb_q.push_back(e);
    start = 1'b1; op_a = a; op_b = b; carry_in = cin; sub = sb;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'b1; sub = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; lat = i; end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(NB));
    compare_out(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_held"}, 64'(result), 64'(e.res));
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] btb_a[3];
    logic [W-1:0] btb_b[3];

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_cout",   64'(carry_out), 64'(0));
    chk("rst_ovf",    64'(overflow), 64'(0));

    // Start presented together with reset release.
    rst_n = 1'b1;
    do_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("ovf",        32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("cin",        32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0);
    do_op("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op("random",     W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    do_op("sub_neg",    32'd5, 32'd7, 1'b0, 1'b1);
    do_op("sub_pos",    32'd7, 32'd5, 1'b0, 1'b1);
    do_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
`endif

    // start held high: back-to-back operations, operands scrambled mid-ADD.
    btb_a[0] = 32'hDEAD_BEEF; btb_b[0] = 32'h0101_0101;
    btb_a[1] = 32'h0000_FFFF; btb_b[1] = 32'h0000_0001;
    btb_a[2] = 32'h4000_0000; btb_b[2] = 32'h4000_0000;
    start = 1'b1; op_a = btb_a[0]; op_b = btb_b[0]; carry_in = 1'b0; sub = 1'b0;
    sb_q.push_back(model(btb_a[0], btb_b[0], 1'b0, 1'b0));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("btb_busy", 64'(busy), 64'(1));
      op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'b1;
      for (int j = 0; j < int'(NB) - 1; j++) begin
        @(negedge clk);
        chk("btb_no_done", 64'(done), 64'(0));
        op_a = W'($urandom); op_b = W'($urandom);
      end
      @(negedge clk);
      chk("btb_done", 64'(done), 64'(1));
      compare_out("btb");
      if (n < 2) begin
        op_a = btb_a[n+1]; op_b = btb_b[n+1]; carry_in = 1'b0;
        sb_q.push_back(model(btb_a[n+1], btb_b[n+1], 1'b0, 1'b0));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("btb_end_done", 64'(done), 64'(0));
    chk("btb_end_busy", 64'(busy), 64'(0));

    // Reset in the second ADD cycle aborts the operation with no done pulse.
    start = 1'b1; op_a = 32'h1111_1111; op_b = 32'h2222_2222; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   64'(busy), 64'(0));
    chk("abort_done",   64'(done), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_cout",   64'(carry_out), 64'(0));
    chk("abort_ovf",    64'(overflow), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      chk("abort_no_done", 64'(done), 64'(0));
    end
    do_op("after_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
